// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and counter sizing for reset_release_sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {SYNC, HOLD, RELEASE, RUN, SWHOLD, SWACK, SWREL} state_t;

    function automatic int cnt_width(input int hold, input int gap);
        return $clog2((hold > gap ? hold : gap) + 1);
    endfunction

endpackage

// File: rtl/reset_release_sequencer_if.sv
// reset_release_sequencer_if: software reset handshake and sequenced reset outputs.
interface reset_release_sequencer_if #(parameter int NUM_OUTS = 4);

    logic                sw_rst_req;
    logic                sw_rst_ack;
    logic                done;
    logic [NUM_OUTS-1:0] rst_out;

    modport master (output sw_rst_req, input sw_rst_ack, done, rst_out);
    modport slave  (input sw_rst_req, output sw_rst_ack, done, rst_out);

endinterface

// File: rtl/reset_sync_chain.sv
// reset_sync_chain: asynchronous-assert, synchronous-release reset synchronizer.
module reset_sync_chain #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain <= '0;
        else        r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_rst_n = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: ordered, spaced release of NUM_OUTS resets from one async reset.
// Define RESET_SEQ_SW_RESET_EN to enable the software reset req/ack handshake.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int NUM_OUTS    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    reset_release_sequencer_if.slave bus
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    state_t              r_state, w_state;
    logic [CW-1:0]       r_cnt, w_cnt;
    logic [NUM_OUTS-1:0] r_rst_out, w_rst_out, w_shift;
    logic                r_done, w_done, w_sync, w_go_rel;
`ifdef RESET_SEQ_SW_RESET_EN
    logic                r_ack, w_ack;
`endif

    reset_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (w_sync)
    );

    assign w_shift = r_rst_out << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SYNC;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_rst_out <= w_rst_out;
            r_done    <= w_done;
        end
    end

    // The synchronizer's first high edge already counts as the first hold cycle.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_rst_out = r_rst_out;
        w_done    = r_done;
        w_go_rel  = 1'b0;
`ifdef RESET_SEQ_SW_RESET_EN
        w_ack     = r_ack;
`endif
        case (r_state)
            SYNC: begin
                if (w_sync && HOLD_LAST == '0) w_go_rel = 1'b1;
                else if (w_sync) begin
                    w_state = HOLD;
                    w_cnt   = CW'(1);
                end
            end
            HOLD:    if (r_cnt >= HOLD_LAST) w_go_rel = 1'b1; else w_cnt = r_cnt + CW'(1);
            RELEASE: if (r_cnt >= GAP_LAST) w_go_rel = 1'b1; else w_cnt = r_cnt + CW'(1);
            RUN: begin
`ifdef RESET_SEQ_SW_RESET_EN
                if (bus.sw_rst_req) begin
                    w_state   = SWHOLD;
                    w_cnt     = '0;
                    w_rst_out = '1;
                    w_done    = 1'b0;
                end
`endif
            end
`ifdef RESET_SEQ_SW_RESET_EN
            SWHOLD: begin
                if (r_cnt >= HOLD_LAST) begin
                    w_state = SWACK;
                    w_ack   = 1'b1;
                    w_cnt   = '0;
                end else w_cnt = r_cnt + CW'(1);
            end
            SWACK: begin
                if (!bus.sw_rst_req) begin
                    w_state = SWREL;
                    w_ack   = 1'b0;
                end
            end
            SWREL: w_go_rel = 1'b1;
`endif
            default: w_state = SYNC;
        endcase
        // Each release shifts one more zero in from bit 0; all zeros means done.
        if (w_go_rel) begin
            w_rst_out = w_shift;
            w_cnt     = '0;
            w_done    = (w_shift == '0);
            w_state   = (w_shift == '0) ? RUN : RELEASE;
        end
    end

`ifdef RESET_SEQ_SW_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ack <= 1'b0;
        else        r_ack <= w_ack;
    end
    assign bus.sw_rst_ack = r_ack;
`else
    assign bus.sw_rst_ack = 1'b0;
`endif

    assign bus.rst_out = r_rst_out;
    assign bus.done    = r_done;

endmodule

// File: doc/reset_release_sequencer.md
# reset_release_sequencer

Generates an ordered set of reset outputs from one asynchronous active-low input reset. All outputs assert immediately and asynchronously. Deassertion of the input is synchronized to the clock. The outputs are then released one at a time, in index order, with fixed spacing between them. The block sits at the root of each clock domain, ahead of the asynchronously reset registers it drives, and also supports a software reset request through a four-phase req/ack handshake.

## Interface
- `SYNC_STAGES`, 3: flops in the deassertion synchronizer; must be ≥2.
- `NUM_OUTS`, 4: number of sequenced reset outputs; must be ≥1.
- `HOLD_CYCLES`, 16: cycles that all outputs stay asserted after synchronized deassertion or a software request; must be ≥1.
- `GAP_CYCLES`, 4: cycles between successive output releases; must be ≥1.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw_rst_req` in 1: software reset request, level-sensitive, four-phase.
- `sw_rst_ack` out 1: software reset acknowledge.
- `rst_out` out NUM_OUTS: active-high resets; bit i is released i-th.
- `done` out 1: all outputs released; block is in RUN.

## Operation
- Reset values: `rst_out` = all ones, `done` = 0, `sw_rst_ack` = 0, state = SYNC, counters = 0.
- **SYNC.** Wait for the synchronizer output to go high, then go to HOLD.
- **HOLD.** Count HOLD_CYCLES, then go to RELEASE.
- **RELEASE.**
  - Deassert `rst_out[0]` on the entry edge.
  - Deassert each further index i GAP_CYCLES later than index i-1.
  - On the edge that releases the last index, raise `done` and go to RUN.
- **RUN.** If `sw_rst_req` is sampled high, go to SWHOLD.
- **SWHOLD.**
  - Assert all `rst_out` and clear `done` on the entry edge.
  - Count HOLD_CYCLES, then raise `sw_rst_ack` and go to SWACK.
- **SWACK.** When `sw_rst_req` is sampled low, drop `sw_rst_ack` and go to SWREL.
- **SWREL.** Wait one cycle, then go to RELEASE.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). Counters saturate and never wrap.
- Boundary rules:
  - `rst_n` low at any time, including mid-sequence, mid-handshake, or a glitch shorter than one clock: all outputs return to their reset values asynchronously, with no clock edge needed. The full sequence restarts from SYNC.
  - `sw_rst_req` high outside RUN: ignored; it is sampled on the first RUN edge.
  - `sw_rst_req` dropped during SWHOLD: ack still rises after the hold, then falls on the next edge.
  - A new request in SWACK before ack falls is impossible by protocol; req must fall first.

## Timing
- Edge k is the k-th rising edge with `rst_n` high.
- The synchronizer output is high after edge SYNC_STAGES. HOLD then starts.
- `rst_out[i]` falls after edge SYNC_STAGES+HOLD_CYCLES+i·GAP_CYCLES.
- With defaults: bit 0 falls at edge 19, bit 1 at 23, bit 2 at 27, bit 3 at 31; `done` rises at 31.
- Software reset, with the request sampled at edge E:
  - All outputs assert after E.
  - `sw_rst_ack` rises after E+HOLD_CYCLES.
- Software reset, with req sampled low at edge F:
  - `sw_rst_ack` falls after F.
  - `rst_out[i]` falls after F+1+i·GAP_CYCLES.
- All outputs are registered. Every flop is asynchronously reset by `rst_n`.

## Configuration
- `RESET_SEQ_SW_RESET_EN` defined: SWHOLD, SWACK and SWREL are present and the handshake works as described.
- `RESET_SEQ_SW_RESET_EN` undefined:
  - `sw_rst_req` is ignored.
  - `sw_rst_ack` is tied to 0.
  - RUN is terminal until `rst_n` is asserted.

## Structure
- Shared package `reset_seq_pkg` holds:
  - the state enum (SYNC, HOLD, RELEASE, RUN, SWHOLD, SWACK, SWREL);
  - the counter-width helper function.
- Sub-module `reset_sync_chain` (parameter SYNC_STAGES):
  - a shift chain of flops that asynchronously clear on `rst_n` low and shift in 1;
  - output `sync_rst_n`.

## Test plan
- Power-on, default parameters: `rst_n` low for 5 cycles, then high. Bits 0–3 fall after edges 19, 23, 27, 31; `done` is 1 after edge 31; ack stays 0.
- Mid-sequence reset: drop `rst_n` between edges 24 and 25 with no clock edge. All `rst_out` become 1 and `done` becomes 0 immediately. Release it again and the same edge offsets from the new release hold.
- Software reset: req high sampled at edge 50. All outputs are 1 after 50 and ack is 1 after 66. Req low sampled at edge 70: ack is 0 after 70, bit 0 falls after 71, bit 3 after 83, `done` is 1 after 83.
- Early request: req high from edge 10. The sequence is unaffected; `done` rises after 31; the request is taken at edge 32 and ack rises after 48.
- Macro undefined: toggle req repeatedly in RUN. Ack stays 0, `rst_out` stays 0 and `done` stays 1.
- Glitch: a 1 ns `rst_n` low pulse in RUN. All outputs assert, and the full 31-edge sequence repeats.
